// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Purpose:
//   Bridges a core-side request/grant/rvalid data port onto an APB3 master
//   interface with a single transfer outstanding at a time. Requests are
//   range-checked and sub-word writes are rejected locally, without touching
//   the bus. Accesses whose slave never asserts pready are aborted after a
//   bounded number of ACCESS cycles. Every granted request receives exactly
//   one rvalid_o strobe.
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   req_i           - core request
//   addr_i          - byte address
//   we_i            - 1 = write
//   be_i            - byte enables (writes must be full-word)
//   wdata_i         - write data
//   gnt_o           - request accepted this cycle (combinational)
//   rvalid_o        - one-cycle response strobe
//   rdata_o         - read data, meaningful while rvalid_o = 1
//   err_o           - error flag, meaningful while rvalid_o = 1
//   paddr, pwdata, pwrite, psel, penable  - APB master outputs
//   prdata, pready, pslverr               - APB slave responses
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,   // fixed at 32 in this revision
    parameter logic [31:0] BASE_ADDR      = 32'h1A10_0000,
    parameter logic [31:0] END_ADDR       = 32'h1A11_7FFF,
    parameter int unsigned TIMEOUT_CYCLES = 255   // must be >= 1
) (
    input  logic                      clk,
    input  logic                      rst,

    // Core-side port
    input  logic                      req_i,
    input  logic [31:0]               addr_i,
    input  logic                      we_i,
    input  logic [3:0]                be_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,

    // APB3 master port
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    // Request latches driving the APB address/data phase
    logic [APB_ADDR_WIDTH-1:0]   r_addr;
    logic [APB_DATA_WIDTH-1:0]   r_wdata;
    logic                        r_we;

    // Captured response
    logic [APB_DATA_WIDTH-1:0]   r_rdata;
    logic                        r_err;

    // ACCESS-phase wait counter
    logic [CNT_W-1:0]            r_cnt;

    logic                        w_grant;
    logic                        w_in_range;
    logic                        w_bad;
    logic                        w_done;
    logic                        w_timeout;

    // -------------------------------------------------------------------------
    // Request classification (only meaningful in the grant cycle). Byte
    // enables are only consulted here; reads ignore them entirely.
    // -------------------------------------------------------------------------
    assign w_grant    = req_i && (r_state == S_IDLE) && !rst;
    assign w_in_range = (addr_i >= BASE_ADDR) && (addr_i <= END_ADDR);
    assign w_bad      = !w_in_range || (we_i && (be_i != 4'hF));

    // pready wins over the timeout when both land in the same cycle.
    assign w_done     = (r_state == S_ACCESS) && pready;
    assign w_timeout  = (r_state == S_ACCESS) && !pready && (r_cnt == CNT_LAST);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and control outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        psel        = 1'b0;
        penable     = 1'b0;
        rvalid_o    = 1'b0;
        gnt_o       = w_grant;

        unique case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    // Bad requests skip the bus and answer next cycle.
                    w_state_nxt = w_bad ? S_RESP : S_SETUP;
                end
            end

            S_SETUP: begin
                psel        = 1'b1;
                w_state_nxt = S_ACCESS;
            end

            S_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end

            S_RESP: begin
                // psel is low here, which guarantees the idle gap between
                // transfers; gnt_o is already 0 because the state is not IDLE.
                rvalid_o    = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request latches, response capture and timeout counter
    // -------------------------------------------------------------------------
    // NOTE: these are a handful of plain registers, not a memory array, so they
    // are all reset; paddr, pwdata and rdata_o are required to read 0 after
    // reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // Latches only move on grant, so the APB address/data phase is
            // stable from SETUP through the end of ACCESS.
            if (w_grant) begin
                r_addr  <= addr_i[APB_ADDR_WIDTH-1:0];
                r_wdata <= wdata_i;
                r_we    <= we_i;
            end

            if (w_grant && w_bad) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end else if (w_done) begin
                // pslverr only matters in this psel && penable && pready cycle.
                r_rdata <= r_we ? '0 : prdata;
                r_err   <= pslverr;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end

            // Counts wait cycles while in ACCESS; clears whenever ACCESS ends.
            if ((r_state == S_ACCESS) && !pready && !w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign paddr   = r_addr;
    assign pwdata  = r_wdata;
    assign pwrite  = r_we;
    assign rdata_o = r_rdata;
    assign err_o   = r_err;

    // -------------------------------------------------------------------------
    // Protocol invariants
    // -------------------------------------------------------------------------
    a_penable_needs_psel : assert property (@(posedge clk) disable iff (rst)
        penable |-> psel);

    a_rvalid_single : assert property (@(posedge clk) disable iff (rst)
        rvalid_o |=> !rvalid_o);

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Directed bench for apb_master_bridge (TIMEOUT_CYCLES = 8). Inputs change 1
// time unit after the rising edge; outputs are sampled on the falling edge.
// Cycle 0 is the cycle in which the request is presented and granted.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .BASE_ADDR      (32'h1A10_0000),
        .END_ADDR       (32'h1A11_7FFF),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pwrite   (pwrite),
        .psel     (psel),
        .penable  (penable),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    // Drives one request and acts as the slave. waits < 0 means the slave
    // never asserts pready. Returns what it observed; callers compare.
    task automatic do_txn(
        input  logic [31:0] a,
        input  logic        w,
        input  logic [3:0]  b,
        input  logic [31:0] wd,
        input  int          waits,
        input  logic [31:0] prd,
        input  logic        serr,
        input  bit          hold,
        output int          gnt0,
        output int          gnt_extra,
        output int          first_sel,
        output int          sel_n,
        output int          pen_n,
        output int          rv_c,
        output logic [31:0] rd,
        output logic        er,
        output int          apb_bad
    );
        int acc;
        bit seen;
        gnt0 = 0; gnt_extra = 0; first_sel = -1; sel_n = 0; pen_n = 0;
        rv_c = -1; rd = 'x; er = 1'bx; apb_bad = 0; acc = 0; seen = 0;
        @(posedge clk); #1;
        req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = wd;
        pready = 1'b0; prdata = 32'hBAD0_BAD0; pslverr = 1'b1;
        @(negedge clk);
        gnt0 = int'(gnt_o);
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge clk); #1;
            if (!hold) begin
                // Scramble the core inputs so only the latched copy can be used.
                req_i = 1'b0; addr_i = 32'hDEAD_BEEF; we_i = ~w; wdata_i = 32'h0F0F_0F0F;
            end
            // Noise on prdata/pslverr while not ready must be ignored.
            pready = 1'b0; prdata = 32'hBAD0_BAD0; pslverr = 1'b1;
            if (psel && penable) begin
                if (waits >= 0 && acc == waits) begin
                    pready = 1'b1; prdata = prd; pslverr = serr;
                end
                acc++;
            end
            @(negedge clk);
            if (gnt_o) gnt_extra++;
            if (psel) begin
                sel_n++;
                if (first_sel < 0) first_sel = c;
                if (paddr !== a || pwrite !== w || pwdata !== wd) apb_bad++;
            end
            if (penable) begin
                pen_n++;
                if (!psel) apb_bad++;
            end
            if (rvalid_o) begin
                rv_c = c; rd = rdata_o; er = err_o; seen = 1;
            end
        end
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        if (!hold) req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_i = 1'b1; addr_i = 32'h1A10_0000; we_i = 1'b1; be_i = 4'hF;
        wdata_i = 32'hFFFF_FFFF; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (psel !== 1'b0)     begin errors++; $display("FAIL reset_psel got %b exp 0", psel); end
        checks++; if (penable !== 1'b0)  begin errors++; $display("FAIL reset_penable got %b exp 0", penable); end
        checks++; if (pwrite !== 1'b0)   begin errors++; $display("FAIL reset_pwrite got %b exp 0", pwrite); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid_o); end
        checks++; if (gnt_o !== 1'b0)    begin errors++; $display("FAIL reset_gnt got %b exp 0", gnt_o); end
        checks++; if (paddr !== 32'h0)   begin errors++; $display("FAIL reset_paddr got %h exp 0", paddr); end
        checks++; if (pwdata !== 32'h0)  begin errors++; $display("FAIL reset_pwdata got %h exp 0", pwdata); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata_o); end
        checks++; if (err_o !== 1'b0)    begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
        @(posedge clk); #1;
        rst = 1'b0; req_i = 1'b0;
    endtask

    task automatic test_read();
        int g, ge, fs, sn, pn, rv, ab; logic [31:0] rd; logic er;
        do_txn(32'h1A10_1000, 1'b0, 4'hF, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b0,
               g, ge, fs, sn, pn, rv, rd, er, ab);
        checks++; if (g !== 1)              begin errors++; $display("FAIL read_gnt got %0d exp 1", g); end
        checks++; if (fs !== 1)             begin errors++; $display("FAIL read_first_psel got %0d exp 1", fs); end
        checks++; if (sn !== 2)             begin errors++; $display("FAIL read_psel_cycles got %0d exp 2", sn); end
        checks++; if (pn !== 1)             begin errors++; $display("FAIL read_penable_cycles got %0d exp 1", pn); end
        checks++; if (rv !== 3)             begin errors++; $display("FAIL read_rvalid_cycle got %0d exp 3", rv); end
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL read_rdata got %h exp cafef00d", rd); end
        checks++; if (er !== 1'b0)          begin errors++; $display("FAIL read_err got %b exp 0", er); end
        checks++; if (ab !== 0)             begin errors++; $display("FAIL read_apb_stable got %0d exp 0", ab); end
        checks++; if (ge !== 0)             begin errors++; $display("FAIL read_extra_gnt got %0d exp 0", ge); end
    endtask

    task automatic test_write_wait();
        int g, ge, fs, sn, pn, rv, ab; logic [31:0] rd; logic er;
        do_txn(32'h1A10_3004, 1'b1, 4'hF, 32'h1234_5678, 3, 32'hFFFF_FFFF, 1'b0, 1'b0,
               g, ge, fs, sn, pn, rv, rd, er, ab);
        checks++; if (g !== 1)      begin errors++; $display("FAIL write_gnt got %0d exp 1", g); end
        checks++; if (sn !== 5)     begin errors++; $display("FAIL write_psel_cycles got %0d exp 5", sn); end
        checks++; if (pn !== 4)     begin errors++; $display("FAIL write_access_cycles got %0d exp 4", pn); end
        checks++; if (rv !== 6)     begin errors++; $display("FAIL write_rvalid_cycle got %0d exp 6", rv); end
        checks++; if (er !== 1'b0)  begin errors++; $display("FAIL write_err got %b exp 0", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL write_rdata got %h exp 0", rd); end
        checks++; if (ab !== 0)     begin errors++; $display("FAIL write_apb_stable got %0d exp 0", ab); end
    endtask

    task automatic test_bad_and_bounds();
        logic [31:0] ta [6];
        logic        tw [6];
        logic [3:0]  tb [6];
        logic        tbad [6];
        int g, ge, fs, sn, pn, rv, ab; logic [31:0] rd; logic er;
        // out of range, sub-word write, BASE-1, BASE, END (be ignored on read), full write at END
        ta = '{32'h1A11_8000, 32'h1A10_0000, 32'h1A0F_FFFF, 32'h1A10_0000, 32'h1A11_7FFF, 32'h1A11_7FFF};
        tw = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tb = '{4'hF, 4'h3, 4'hF, 4'hF, 4'h0, 4'hF};
        tbad = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_txn(ta[i], tw[i], tb[i], 32'hA5A5_0000 + i, 0, 32'h7700_0000 + i, 1'b0, 1'b0,
                   g, ge, fs, sn, pn, rv, rd, er, ab);
            checks++; if (g !== 1) begin errors++; $display("FAIL bound%0d_gnt got %0d exp 1", i, g); end
            if (tbad[i]) begin
                checks++; if (sn !== 0)     begin errors++; $display("FAIL bad%0d_psel_cycles got %0d exp 0", i, sn); end
                checks++; if (rv !== 1)     begin errors++; $display("FAIL bad%0d_rvalid_cycle got %0d exp 1", i, rv); end
                checks++; if (er !== 1'b1)  begin errors++; $display("FAIL bad%0d_err got %b exp 1", i, er); end
                checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bad%0d_rdata got %h exp 0", i, rd); end
            end else begin
                checks++; if (sn !== 2)    begin errors++; $display("FAIL ok%0d_psel_cycles got %0d exp 2", i, sn); end
                checks++; if (rv !== 3)    begin errors++; $display("FAIL ok%0d_rvalid_cycle got %0d exp 3", i, rv); end
                checks++; if (er !== 1'b0) begin errors++; $display("FAIL ok%0d_err got %b exp 0", i, er); end
                checks++; if (rd !== (tw[i] ? 32'h0 : 32'h7700_0000 + i))
                    begin errors++; $display("FAIL ok%0d_rdata got %h", i, rd); end
            end
        end
    endtask

    task automatic test_timeout();
        int g, ge, fs, sn, pn, rv, ab; logic [31:0] rd; logic er;
        do_txn(32'h1A10_2000, 1'b0, 4'hF, 32'h0, -1, 32'h0, 1'b0, 1'b0,
               g, ge, fs, sn, pn, rv, rd, er, ab);
        checks++; if (pn !== 8)     begin errors++; $display("FAIL tmo_access_cycles got %0d exp 8", pn); end
        checks++; if (sn !== 9)     begin errors++; $display("FAIL tmo_psel_cycles got %0d exp 9", sn); end
        checks++; if (rv !== 10)    begin errors++; $display("FAIL tmo_rvalid_cycle got %0d exp 10", rv); end
        checks++; if (er !== 1'b1)  begin errors++; $display("FAIL tmo_err got %b exp 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL tmo_rdata got %h exp 0", rd); end
        // Following read must complete normally (counter cleared).
        do_txn(32'h1A10_2008, 1'b0, 4'hF, 32'h0, 0, 32'h1357_9BDF, 1'b0, 1'b0,
               g, ge, fs, sn, pn, rv, rd, er, ab);
        checks++; if (rv !== 3)             begin errors++; $display("FAIL post_tmo_rvalid_cycle got %0d exp 3", rv); end
        checks++; if (er !== 1'b0)          begin errors++; $display("FAIL post_tmo_err got %b exp 0", er); end
        checks++; if (rd !== 32'h1357_9BDF) begin errors++; $display("FAIL post_tmo_rdata got %h exp 13579bdf", rd); end
    endtask

    task automatic test_slverr_and_coincide();
        int g, ge, fs, sn, pn, rv, ab; logic [31:0] rd; logic er;
        do_txn(32'h1A10_4000, 1'b0, 4'hF, 32'h0, 1, 32'h0000_0055, 1'b1, 1'b0,
               g, ge, fs, sn, pn, rv, rd, er, ab);
        checks++; if (rv !== 4)             begin errors++; $display("FAIL slverr_rvalid_cycle got %0d exp 4", rv); end
        checks++; if (er !== 1'b1)          begin errors++; $display("FAIL slverr_err got %b exp 1", er); end
        checks++; if (rd !== 32'h0000_0055) begin errors++; $display("FAIL slverr_rdata got %h exp 00000055", rd); end
        // pready on the 8th ACCESS cycle, where the timeout would otherwise fire.
        do_txn(32'h1A10_4004, 1'b0, 4'hF, 32'h0, 7, 32'h8765_4321, 1'b0, 1'b0,
               g, ge, fs, sn, pn, rv, rd, er, ab);
        checks++; if (pn !== 8)             begin errors++; $display("FAIL coincide_access_cycles got %0d exp 8", pn); end
        checks++; if (rv !== 10)            begin errors++; $display("FAIL coincide_rvalid_cycle got %0d exp 10", rv); end
        checks++; if (er !== 1'b0)          begin errors++; $display("FAIL coincide_err got %b exp 0", er); end
        checks++; if (rd !== 32'h8765_4321) begin errors++; $display("FAIL coincide_rdata got %h exp 87654321", rd); end
    endtask

    task automatic test_back_to_back();
        int g, ge, fs, sn, pn, rv, ab; logic [31:0] rd; logic er;
        // req_i stays high throughout: no grant may appear until RESP has passed.
        do_txn(32'h1A10_5000, 1'b0, 4'hF, 32'h0, 0, 32'h1111_2222, 1'b0, 1'b1,
               g, ge, fs, sn, pn, rv, rd, er, ab);
        checks++; if (ge !== 0)             begin errors++; $display("FAIL b2b_gnt_while_busy got %0d exp 0", ge); end
        checks++; if (rd !== 32'h1111_2222) begin errors++; $display("FAIL b2b_first_rdata got %h exp 11112222", rd); end
        do_txn(32'h1A10_5004, 1'b0, 4'hF, 32'h0, 0, 32'h3333_4444, 1'b0, 1'b1,
               g, ge, fs, sn, pn, rv, rd, er, ab);
        req_i = 1'b0;
        checks++; if (g !== 1)              begin errors++; $display("FAIL b2b_second_gnt got %0d exp 1", g); end
        checks++; if (rv !== 3)             begin errors++; $display("FAIL b2b_second_rvalid_cycle got %0d exp 3", rv); end
        checks++; if (rd !== 32'h3333_4444) begin errors++; $display("FAIL b2b_second_rdata got %h exp 33334444", rd); end
    endtask

    task automatic test_reset_mid_access();
        int rv_seen;
        logic [31:0] rd;
        rv_seen = 0; rd = '0;
        @(posedge clk); #1;                       // cycle 0: grant
        req_i = 1'b1; addr_i = 32'h1A10_6000; we_i = 1'b0; be_i = 4'hF; pready = 1'b0;
        @(negedge clk);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %b exp 1", gnt_o); end
        @(posedge clk); #1;                       // cycle 1: SETUP
        req_i = 1'b0;
        @(posedge clk); #1;                       // cycle 2: ACCESS, assert reset
        rst = 1'b1; req_i = 1'b1; addr_i = 32'h1A10_6004;
        @(negedge clk);
        checks++; if (penable !== 1'b1) begin errors++; $display("FAIL rstmid_in_access got %b exp 1", penable); end
        @(posedge clk); #1;                       // cycle 3: back in IDLE, rst still high
        @(negedge clk);
        checks++; if (psel !== 1'b0)     begin errors++; $display("FAIL rstmid_psel got %b exp 0", psel); end
        checks++; if (penable !== 1'b0)  begin errors++; $display("FAIL rstmid_penable got %b exp 0", penable); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid got %b exp 0", rvalid_o); end
        checks++; if (gnt_o !== 1'b0)    begin errors++; $display("FAIL rstmid_gnt_in_rst got %b exp 0", gnt_o); end
        @(posedge clk); #1;                       // cycle 4: rst released, held request granted
        rst = 1'b0;
        @(negedge clk);
        checks++; if (gnt_o !== 1'b1)    begin errors++; $display("FAIL rstmid_regrant got %b exp 1", gnt_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_stale_rvalid got %b exp 0", rvalid_o); end
        for (int c = 0; c < 20 && rv_seen == 0; c++) begin
            @(posedge clk); #1;
            req_i = 1'b0;
            pready = psel && penable;
            prdata = 32'h600D_F00D; pslverr = 1'b0;
            @(negedge clk);
            if (penable) begin
                checks++; if (paddr !== 32'h1A10_6004) begin errors++; $display("FAIL rstmid_paddr got %h exp 1a106004", paddr); end
            end
            if (rvalid_o) begin rv_seen = c + 5; rd = rdata_o; end
        end
        pready = 1'b0;
        checks++; if (rv_seen !== 7)        begin errors++; $display("FAIL rstmid_rvalid_cycle got %0d exp 7", rv_seen); end
        checks++; if (rd !== 32'h600D_F00D) begin errors++; $display("FAIL rstmid_rdata got %h exp 600df00d", rd); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_bad_and_bounds();
        test_timeout();
        test_slverr_and_coincide();
        test_back_to_back();
        test_reset_mid_access();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
